// File: rtl/uart_pkg.sv
// Shared UART definitions: default clocking, bit-period helper and FSM state encoding.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int   DEFAULT_CLK_FREQ = 50_000_000;
    localparam int   DEFAULT_BAUD     = 115_200;
    localparam logic UART_IDLE_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte-write handshake into the buffered UART transmitter.
interface uart_tx_buffered_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 LSB-first UART transmitter fed from a byte FIFO; frames leave back-to-back
// with no idle gap while the FIFO holds data.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk_50M,
    input  logic               rst_n,
    uart_tx_buffered_if.slave  tx_if,
    output logic               rs232_tx,
    output logic               tx_busy,
    output logic               tx_done
);
    localparam int CPB    = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              rs232_tx_q, rs232_tx_d;
    logic              tx_done_q, tx_done_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              baud_last;

    assign tx_if.tx_ready = !fifo_full;
    assign fifo_push      = tx_if.tx_valid && !fifo_full;
    assign baud_last      = (baud_q == BAUD_LAST);
    assign rs232_tx       = rs232_tx_q;
    assign tx_done        = tx_done_q;
    // The line is registered one cycle behind the FSM, so busy also covers the
    // final stop-bit cycle flagged by tx_done.
    assign tx_busy        = (state_q != IDLE) || (fifo_count != '0) || tx_done_q;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_50M),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (tx_if.tx_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        tx_done_d  = 1'b0;
        rs232_tx_d = UART_IDLE_LEVEL;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    state_d  = START;
                end
            end
            START: begin
                rs232_tx_d = ~UART_IDLE_LEVEL;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                rs232_tx_d = shift_q[0];
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d    = '0;
                    tx_done_d = 1'b1;
                    // Chain straight into the next start bit when more data waits.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            rs232_tx_q <= UART_IDLE_LEVEL;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            rs232_tx_q <= rs232_tx_d;
            tx_done_q  <= tx_done_d;
        end
        shift_q <= shift_d;
    end

endmodule
